insn_loader: RTL and testbench
==============================

INSN_LOADER -- requirements
Module: insn_loader

Interface
REQ-001 SHALL have parameter LEN_INSN, default 32, the instruction word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter MEM_INSN_ADDR, default 10, the instruction memory address width; memory depth is 2^MEM_INSN_ADDR words.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid_i  input  1  a byte is offered on byte_i.
REQ-006 SHALL have port byte_i  input  8  program stream byte.
REQ-007 SHALL have port stall_o  output  1  loader cannot accept a byte this cycle.
REQ-008 SHALL have port we_o  output  1  instruction memory write strobe, one cycle per word.
REQ-009 SHALL have port waddr_o  output  MEM_INSN_ADDR  instruction memory write address.
REQ-010 SHALL have port wdata_o  output  LEN_INSN  instruction word to write.
REQ-011 SHALL have port core_rst_o  output  1  held-in-reset to the fetch/decode/execute pipeline while loading.
REQ-012 SHALL have port done_o  output  1  program fully written.
REQ-013 SHALL have port err_o  output  1  header word count exceeds memory depth.

Function
REQ-014 SHALL accept a byte exactly when valid_i=1 and stall_o=0 at posedge clk; bytes offered under stall_o=1 are not consumed and must be held by the sender.
REQ-015 SHALL interpret the stream as a 16-bit big-endian word count N (2 bytes), then N words of LEN_INSN/8 bytes each, big-endian (first byte is bits LEN_INSN-1..LEN_INSN-8).
REQ-016 SHALL implement states S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR; reset enters S_LEN_HI.
REQ-017 S_LEN_HI: accepted byte -> N[15:8], go S_LEN_LO.
REQ-018 S_LEN_LO: accepted byte -> N[7:0]; if N=0 go S_DONE; if N > 2^MEM_INSN_ADDR go S_ERR; else go S_DATA with word address 0 and byte counter 0.
REQ-019 S_DATA: each accepted byte shifts into an assembly register; on the last byte of a word, the next cycle SHALL present we_o=1, waddr_o=current word address, wdata_o=assembled word, for exactly one cycle.
REQ-020 Word address SHALL increment by 1 after each write; byte counter SHALL wrap to 0 after LEN_INSN/8 bytes.
REQ-021 On the last byte of word N-1 the FSM SHALL go S_DONE on the same edge that raises we_o for that word.
REQ-022 stall_o SHALL be 0 in S_LEN_HI, S_LEN_LO, S_DATA and 1 in S_DONE and S_ERR; no byte-level backpressure otherwise (memory accepts a write every cycle).
REQ-023 core_rst_o SHALL be 1 in every state except S_DONE and SHALL fall on the edge after the final we_o pulse (one cycle after entering S_DONE); for N=0 it falls one cycle after entering S_DONE.
REQ-024 done_o SHALL rise on the same edge core_rst_o falls and stay 1 until rst.
REQ-025 err_o SHALL be 1 while in S_ERR; S_ERR and S_DONE SHALL be exited only by rst.
REQ-026 N = 2^MEM_INSN_ADDR SHALL be legal, filling the memory; the address counter SHALL never wrap during a load.
REQ-027 All outputs SHALL be registered except stall_o, which is a decode of state only.

Reset
REQ-028 rst=1 at posedge SHALL, regardless of state (including mid-word), force S_LEN_HI, clear N, counters and assembly register, and drive we_o=0, waddr_o=0, wdata_o=0, core_rst_o=1, done_o=0, err_o=0, stall_o=0.
REQ-029 A partially assembled word at reset SHALL be discarded, never written.

Verification
REQ-030 LEN_INSN=32: bytes 00 02 DE AD BE EF 01 02 03 04 -> we_o pulses with (0, 0xDEADBEEF) then (1, 0x01020304); core_rst_o falls and done_o rises one cycle after the second pulse.
REQ-031 Bytes 00 00 -> no we_o; done_o=1 and core_rst_o=0 one cycle after entering S_DONE; stall_o=1 thereafter.
REQ-032 MEM_INSN_ADDR=10, header 04 01 (N=1025) -> err_o=1, stall_o=1, core_rst_o stays 1, no we_o.
REQ-033 Valid_i toggled randomly with 1-in-3 gaps over a 3-word load -> identical writes to a gap-free load; no byte lost or duplicated.
REQ-034 rst asserted after 2 of 4 bytes of word 1 -> no write of word 1; restarting stream 00 01 11 22 33 44 -> single write (0, 0x11223344).

Source files
------------

// File: rtl/insn_loader.sv
// insn_loader: receives a byte-serial program image and writes it into the
// instruction memory, holding the core in reset until the load is complete.
//
// Stream format: 16-bit big-endian word count N, then N big-endian words of
// LEN_INSN/8 bytes each.
//
// Ports
//   clk        : single clock, all state changes on posedge
//   rst        : synchronous active-high reset
//   valid_i    : a byte is offered on byte_i
//   byte_i     : program stream byte
//   stall_o    : loader cannot accept a byte this cycle (state decode)
//   we_o       : instruction memory write strobe, one cycle per word
//   waddr_o    : instruction memory write address
//   wdata_o    : instruction word to write
//   core_rst_o : holds the fetch/decode/execute pipeline in reset while loading
//   done_o     : program fully written (sticky until rst)
//   err_o      : header word count exceeded memory depth (sticky until rst)
module insn_loader #(
  parameter int LEN_INSN      = 32,
  parameter int MEM_INSN_ADDR = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [7:0]               byte_i,
  output logic                     stall_o,
  output logic                     we_o,
  output logic [MEM_INSN_ADDR-1:0] waddr_o,
  output logic [LEN_INSN-1:0]      wdata_o,
  output logic                     core_rst_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int BYTES = LEN_INSN / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [15:0]              r_n;
  logic [MEM_INSN_ADDR-1:0] r_addr;
  logic [BCW-1:0]           r_bcnt;
  logic [LEN_INSN-1:0]      r_asm;
  logic                     r_we;
  logic [MEM_INSN_ADDR-1:0] r_waddr;
  logic [LEN_INSN-1:0]      r_wdata;
  logic                     r_core_rst;
  logic                     r_done;
  logic                     r_err;

  logic                     w_accept;
  logic [15:0]              w_n_full;
  logic                     w_too_big;
  logic                     w_last_byte;
  logic                     w_last_word;
  logic [LEN_INSN-1:0]      w_word;

  assign stall_o     = (r_state == S_DONE) || (r_state == S_ERR);
  assign w_accept    = valid_i && !stall_o;
  assign w_n_full    = {r_n[15:8], byte_i};
  // Depth compared in 32 bits so that N = 2^MEM_INSN_ADDR itself stays legal.
  assign w_too_big   = {16'd0, w_n_full} > (32'd1 << MEM_INSN_ADDR);
  assign w_last_byte = (r_bcnt == BCW'(BYTES - 1));
  assign w_last_word = (32'(r_addr) == (32'(r_n) - 32'd1));
  // Shift the new byte in at the bottom; the oldest byte drops off the top.
  assign w_word      = LEN_INSN'({r_asm, byte_i});

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LEN_HI;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_n_full == 16'd0) w_next = S_DONE;
          else if (w_too_big)    w_next = S_ERR;
          else                   w_next = S_DATA;
        end
      end
      S_DATA:   if (w_accept && w_last_byte && w_last_word) w_next = S_DONE;
      S_DONE:   w_next = S_DONE;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n        <= '0;
      r_addr     <= '0;
      r_bcnt     <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      // Core reset releases one cycle after S_DONE is reached, i.e. after the
      // final write pulse has been presented to memory.
      r_core_rst <= (r_state != S_DONE);
      r_done     <= (r_state == S_DONE);
      // Registered from next state so err_o tracks S_ERR cycle for cycle.
      r_err      <= (w_next == S_ERR);
      case (r_state)
        S_LEN_HI: if (w_accept) r_n[15:8] <= byte_i;
        S_LEN_LO: begin
          if (w_accept) begin
            r_n[7:0] <= byte_i;
            r_addr   <= '0;
            r_bcnt   <= '0;
            r_asm    <= '0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            if (w_last_byte) begin
              r_we    <= 1'b1;
              r_waddr <= r_addr;
              r_wdata <= w_word;
              r_bcnt  <= '0;
              r_asm   <= '0;
              // Address stops at the final word so a full-depth load never wraps.
              if (!w_last_word) r_addr <= r_addr + MEM_INSN_ADDR'(1);
            end else begin
              r_asm  <= w_word;
              r_bcnt <= r_bcnt + BCW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign we_o       = r_we;
  assign waddr_o    = r_waddr;
  assign wdata_o    = r_wdata;
  assign core_rst_o = r_core_rst;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule

// File: tb/tb_insn_loader.sv
module tb_insn_loader;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  byte_i;
  logic        stall_o;
  logic        we_o;
  logic [9:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        core_rst_o;
  logic        done_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  log_a[$];
  logic [31:0] log_d[$];

  insn_loader #(.LEN_INSN(32), .MEM_INSN_ADDR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .byte_i    (byte_i),
    .stall_o   (stall_o),
    .we_o      (we_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o),
    .core_rst_o(core_rst_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: records every memory write pulse.
  always @(posedge clk) begin
    #1;
    if (we_o === 1'b1) begin
      log_a.push_back(waddr_o);
      log_d.push_back(wdata_o);
    end
  end

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  b;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        crst;
    logic        done;
    logic        err;
    logic        stall;
    string       name;
  } vec_t;

  vec_t tv[$];

  task automatic step(input logic r, input logic v, input logic [7:0] b);
    rst = r; valid_i = v; byte_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_flags(input string nm, input logic we, input logic crst,
                             input logic done, input logic err, input logic stall);
    check(nm, {27'd0, we_o, core_rst_o, done_o, err_o, stall_o},
              {27'd0, we, crst, done, err, stall});
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] b,
                              input logic we, input logic [9:0] a, input logic [31:0] d,
                              input logic crst, input logic done, input logic err,
                              input logic stall, input string nm);
    vec_t x;
    x.rst = r; x.vld = v; x.b = b; x.we = we; x.addr = a; x.data = d;
    x.crst = crst; x.done = done; x.err = err; x.stall = stall; x.name = nm;
    return x;
  endfunction

  initial begin
    logic [7:0] stream[$];
    int idx;
    int cyc;
    int bad;

    rst = 1'b1; valid_i = 1'b0; byte_i = 8'h00;

    // Two-word load: header 00 02, words DEADBEEF and 01020304.
    tv.push_back(mk(1,0,8'h00, 0,10'd0,32'h0,          1,0,0,0, "reset"));
    tv.push_back(mk(0,1,8'h00, 0,10'd0,32'h0,          1,0,0,0, "len_hi"));
    tv.push_back(mk(0,1,8'h02, 0,10'd0,32'h0,          1,0,0,0, "len_lo"));
    tv.push_back(mk(0,1,8'hDE, 0,10'd0,32'h0,          1,0,0,0, "w0_b0"));
    tv.push_back(mk(0,1,8'hAD, 0,10'd0,32'h0,          1,0,0,0, "w0_b1"));
    tv.push_back(mk(0,1,8'hBE, 0,10'd0,32'h0,          1,0,0,0, "w0_b2"));
    tv.push_back(mk(0,1,8'hEF, 1,10'd0,32'hDEADBEEF,   1,0,0,0, "w0_write"));
    tv.push_back(mk(0,1,8'h01, 0,10'd0,32'h0,          1,0,0,0, "w1_b0"));
    tv.push_back(mk(0,1,8'h02, 0,10'd0,32'h0,          1,0,0,0, "w1_b1"));
    tv.push_back(mk(0,1,8'h03, 0,10'd0,32'h0,          1,0,0,0, "w1_b2"));
    tv.push_back(mk(0,1,8'h04, 1,10'd1,32'h01020304,   1,0,0,1, "w1_write"));
    tv.push_back(mk(0,0,8'h00, 0,10'd0,32'h0,          0,1,0,1, "done_rise"));
    tv.push_back(mk(0,1,8'h55, 0,10'd0,32'h0,          0,1,0,1, "done_hold"));
    // Empty program.
    tv.push_back(mk(1,0,8'h00, 0,10'd0,32'h0,          1,0,0,0, "reset2"));
    tv.push_back(mk(0,1,8'h00, 0,10'd0,32'h0,          1,0,0,0, "n0_hi"));
    tv.push_back(mk(0,1,8'h00, 0,10'd0,32'h0,          1,0,0,1, "n0_enter_done"));
    tv.push_back(mk(0,0,8'h00, 0,10'd0,32'h0,          0,1,0,1, "n0_done"));
    // Oversized header N=1025 with 1024-word memory.
    tv.push_back(mk(1,0,8'h00, 0,10'd0,32'h0,          1,0,0,0, "reset3"));
    tv.push_back(mk(0,1,8'h04, 0,10'd0,32'h0,          1,0,0,0, "err_hi"));
    tv.push_back(mk(0,1,8'h01, 0,10'd0,32'h0,          1,0,1,1, "err_enter"));
    tv.push_back(mk(0,1,8'hAA, 0,10'd0,32'h0,          1,0,1,1, "err_hold"));
    tv.push_back(mk(0,1,8'hBB, 0,10'd0,32'h0,          1,0,1,1, "err_hold2"));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].vld, tv[i].b);
      check_flags(tv[i].name, tv[i].we, tv[i].crst, tv[i].done, tv[i].err, tv[i].stall);
      if (tv[i].we) begin
        check({tv[i].name, "_addr"}, {22'd0, waddr_o}, {22'd0, tv[i].addr});
        check({tv[i].name, "_data"}, wdata_o, tv[i].data);
      end
    end

    // Reset mid-word: word 1 partially sent, then restart with N=1.
    step(1, 0, 8'h00);
    log_a.delete(); log_d.delete();
    stream = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    foreach (stream[k]) step(0, 1, stream[k]);
    step(1, 0, 8'h00);
    check_flags("midword_reset", 0, 1, 0, 0, 0);
    check("midword_reset_wdata", wdata_o, 32'h0);
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (stream[k]) step(0, 1, stream[k]);
    step(0, 0, 8'h00);
    check("midword_nwrites", log_a.size(), 2);
    if (log_a.size() == 2) begin
      check("midword_w0", log_d[0], 32'hAABBCCDD);
      check("restart_addr", {22'd0, log_a[1]}, 32'd0);
      check("restart_data", log_d[1], 32'h11223344);
    end
    check_flags("restart_done", 0, 0, 1, 0, 1);

    // Three-word load with random valid gaps.
    step(1, 0, 8'h00);
    log_a.delete(); log_d.delete();
    stream = '{8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 8'h66, 8'h77, 8'h88,
               8'hF1, 8'hE2, 8'hD3, 8'hC4};
    idx = 0; cyc = 0;
    while (idx < stream.size() && cyc < 500) begin
      if ($urandom_range(0, 2) == 0) step(0, 0, 8'hFF);
      else begin
        step(0, 1, stream[idx]);
        idx++;
      end
      cyc++;
    end
    check("gap_stream_consumed", idx, stream.size());
    step(0, 0, 8'h00);
    check("gap_nwrites", log_a.size(), 3);
    if (log_a.size() == 3) begin
      check("gap_w0", {log_a[0], log_d[0]} , {10'd0, 32'h10203040});
      check("gap_w1", {log_a[1], log_d[1]} , {10'd1, 32'h55667788});
      check("gap_w2", {log_a[2], log_d[2]} , {10'd2, 32'hF1E2D3C4});
    end
    check_flags("gap_done", 0, 0, 1, 0, 1);

    // Full-depth load: N = 1024, word i = A5000000 | i.
    step(1, 0, 8'h00);
    log_a.delete(); log_d.delete();
    step(0, 1, 8'h04);
    step(0, 1, 8'h00);
    check_flags("full_hdr_ok", 0, 1, 0, 0, 0);
    for (int w = 0; w < 1024; w++) begin
      logic [31:0] word;
      word = 32'hA5000000 | 32'(w);
      step(0, 1, word[31:24]);
      step(0, 1, word[23:16]);
      step(0, 1, word[15:8]);
      step(0, 1, word[7:0]);
    end
    check_flags("full_last_write", 1, 1, 0, 0, 1);
    step(0, 0, 8'h00);
    check_flags("full_done", 0, 0, 1, 0, 1);
    check("full_nwrites", log_a.size(), 1024);
    bad = 0;
    for (int w = 0; w < log_a.size(); w++)
      if (log_a[w] !== 10'(w) || log_d[w] !== (32'hA5000000 | 32'(w))) bad++;
    check("full_contents_bad", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
